// File: rtl/bangbang_phase_detector.sv
// Alexander bang-bang phase detector: edge/centre sampling, early/late pulse
// generation for the CDR loop filter, recovered bit output and density lock.
module bangbang_phase_detector #(
    parameter int pulse_len = 4,
    parameter int win_len   = 1024,
    parameter int min_trans = 64
) (
    input  logic sys_clk,
    input  logic ext_rst,
    input  logic rx_data,
    input  logic edge_stb,
    input  logic sample_stb,
    output logic up_pulse,
    output logic dn_pulse,
    output logic bit_out,
    output logic bit_valid,
    output logic locked
);

    localparam int CW = $clog2(win_len + 1);

    localparam logic [0:0] ACQ   = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    localparam logic [CW-1:0] WIN_LAST = CW'(win_len - 1);
    localparam logic [CW-1:0] WIN_MAX  = CW'(win_len);
    localparam logic [CW-1:0] MIN_T    = CW'(min_trans);
    localparam logic [7:0]    PLEN     = 8'(pulse_len);

    logic [0:0]    state_q, state_d;
    logic          a_q, a_d;
    logic          t_q, t_d;
    logic          he_q, he_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] samp_q, samp_d;
    logic [CW-1:0] trans_q, trans_d;
    logic          lock_q, lock_d;
    logic          bit_q, bit_d;
    logic          bv_q, bv_d;

    logic          decide;
    logic          dec_up;
    logic [CW-1:0] trans_inc;

    // A decision needs a prior centre sample, an edge in between and a
    // transition; T then matches exactly one of A or B.
    assign decide    = sample_stb && (state_q == TRACK) && he_q && (a_q != rx_data);
    assign dec_up    = (t_q == rx_data);
    assign trans_inc = (decide && (trans_q != WIN_MAX)) ? trans_q + CW'(1) : trans_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        t_d     = t_q;
        he_d    = he_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        samp_d  = samp_q;
        trans_d = trans_q;
        lock_d  = lock_q;
        bit_d   = bit_q;
        bv_d    = 1'b0;

        if (sample_stb) begin
            bit_d = rx_data;
            bv_d  = 1'b1;
            a_d   = rx_data;
            if (state_q == ACQ) begin
                state_d = TRACK;
            end else begin
                he_d = 1'b0;
                if (samp_q == WIN_LAST) begin
                    lock_d  = (trans_inc >= MIN_T);
                    samp_d  = '0;
                    trans_d = '0;
                end else begin
                    samp_d  = samp_q + CW'(1);
                    trans_d = trans_inc;
                end
            end
        end

        // A coincident edge is captured after the decision used the old T.
        if (edge_stb) begin
            t_d  = rx_data;
            he_d = 1'b1;
        end

        if (decide) begin
            cnt_d = PLEN;
            dir_d = dec_up;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge ext_rst) begin
        if (ext_rst) begin
            state_q <= ACQ;
            a_q     <= 1'b0;
            t_q     <= 1'b0;
            he_q    <= 1'b0;
            cnt_q   <= 8'd0;
            dir_q   <= 1'b0;
            samp_q  <= '0;
            trans_q <= '0;
            lock_q  <= 1'b0;
            bit_q   <= 1'b0;
            bv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            t_q     <= t_d;
            he_q    <= he_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            samp_q  <= samp_d;
            trans_q <= trans_d;
            lock_q  <= lock_d;
            bit_q   <= bit_d;
            bv_q    <= bv_d;
        end
    end

    assign up_pulse  = (cnt_q != 8'd0) && dir_q;
    assign dn_pulse  = (cnt_q != 8'd0) && !dir_q;
    assign bit_out   = bit_q;
    assign bit_valid = bv_q;
    assign locked    = lock_q;

endmodule

// File: tb/tb_bangbang_phase_detector.sv
// Randomized and directed bench for bangbang_phase_detector against an
// event-level reference model (decision times, window tallies).
module tb_bangbang_phase_detector;

    localparam int P = 4;
    localparam int W = 1024;
    localparam int M = 64;

    logic sys_clk = 1'b0;
    logic ext_rst = 1'b1;
    logic rx_data = 1'b0;
    logic edge_stb = 1'b0;
    logic sample_stb = 1'b0;
    logic up_pulse, dn_pulse, bit_out, bit_valid, locked;

    bangbang_phase_detector #(.pulse_len(P), .win_len(W), .min_trans(M)) dut (
        .sys_clk(sys_clk), .ext_rst(ext_rst), .rx_data(rx_data),
        .edge_stb(edge_stb), .sample_stb(sample_stb),
        .up_pulse(up_pulse), .dn_pulse(dn_pulse),
        .bit_out(bit_out), .bit_valid(bit_valid), .locked(locked)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: remembers when the last decision happened and its
    // direction, plus per-window sample and transition tallies.
    bit m_trk, m_a, m_t, m_he, m_dir, m_lock, m_bo, m_bv;
    int m_dec, m_samp, m_trans, cyc;
    bit cur_bit;

    function automatic void model_reset();
        m_trk = 0; m_a = 0; m_t = 0; m_he = 0; m_dir = 0;
        m_lock = 0; m_bo = 0; m_bv = 0;
        m_dec = -1000; m_samp = 0; m_trans = 0;
    endfunction

    function automatic void model_step(input bit e, input bit s, input bit r);
        if (s) begin
            m_bo = r;
            m_bv = 1;
            if (m_trk) begin
                if (m_he && (m_a != r)) begin
                    m_dec = cyc;
                    m_dir = (m_t == r);
                    if (m_trans < W) m_trans++;
                end
                m_samp++;
                if (m_samp == W) begin
                    m_lock = (m_trans >= M);
                    m_samp = 0;
                    m_trans = 0;
                end
                m_he = 0;
            end
            m_trk = 1;
            m_a = r;
        end else begin
            m_bv = 0;
        end
        if (e) begin
            m_t = r;
            m_he = 1;
        end
    endfunction

    function automatic bit pulse_on();
        return (cyc - m_dec >= 1) && (cyc - m_dec <= P);
    endfunction

    task automatic tick(input bit e, input bit s, input bit r);
        @(negedge sys_clk);
        chk("up", up_pulse, pulse_on() && m_dir);
        chk("dn", dn_pulse, pulse_on() && !m_dir);
        chk("bit_valid", bit_valid, m_bv);
        if (m_bv) chk("bit_out", bit_out, m_bo);
        chk("locked", locked, m_lock);
        chk("exclusive", up_pulse && dn_pulse, 0);
        edge_stb = e; sample_stb = s; rx_data = r;
        model_step(e, s, r);
        cyc++;
    endtask

    task automatic idle();
        tick(0, 0, 1'($urandom));
    endtask

    task automatic send_bit(input bit b);
        bit ev;
        ev = ($urandom % 2) ? cur_bit : b;
        tick(1, 0, ev);
        idle();
        tick(0, 1, b);
        idle();
        cur_bit = b;
    endtask

    task automatic do_reset();
        #2 ext_rst = 1'b1;
        #1;
        chk("rst_up", up_pulse, 0);
        chk("rst_dn", dn_pulse, 0);
        chk("rst_bo", bit_out, 0);
        chk("rst_bv", bit_valid, 0);
        chk("rst_lock", locked, 0);
        model_reset();
        edge_stb = 0; sample_stb = 0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        ext_rst = 1'b0;
    endtask

    task automatic run_window(input int ntr, input bit prev, input bit exp_lock, input string tag);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) chk("lock_hold", locked, prev);
            send_bit((i < ntr) ? ~cur_bit : cur_bit);
        end
        chk(tag, locked, exp_lock);
    endtask

    task automatic pulse_checks(input string tag, input bit eu, input bit ed);
        chk({tag, "_up"}, up_pulse, eu);
        chk({tag, "_dn"}, dn_pulse, ed);
    endtask

    initial begin
        int last;
        model_reset();
        cyc = 0;
        cur_bit = 0;
        @(negedge sys_clk);
        chk("init_up", up_pulse, 0);
        chk("init_dn", dn_pulse, 0);
        chk("init_bv", bit_valid, 0);
        chk("init_lock", locked, 0);
        ext_rst = 1'b0;

        // Lock windows: 64 transitions locks, 63 unlocks, dense random relocks.
        send_bit(0);
        run_window(M, 0, 1, "lock64");
        run_window(M - 1, 1, 0, "lock63");
        run_window(300 + int'($urandom % 300), 0, 1, "lock_rand");

        // Free-running random strobes, including coincident and missing edges.
        last = -10;
        for (int i = 0; i < 4000; i++) begin
            bit e, s;
            e = 0; s = 0;
            if ((cyc - last >= 2) && ($urandom % 3 == 0)) begin
                int k;
                k = $urandom % 3;
                e = (k != 1);
                s = (k != 0);
                last = cyc;
            end
            tick(e, s, 1'($urandom));
        end

        do_reset();

        // First sample after reset only acquires.
        tick(0, 1, 1);
        idle();
        chk("acq_bv", bit_valid, 1);
        chk("acq_bo", bit_out, 1);
        pulse_checks("acq", 0, 0);
        idle();
        chk("acq_bv_drop", bit_valid, 0);

        // Missing edge: no decision, A becomes 0.
        tick(0, 1, 0);
        for (int k = 1; k <= 4; k++) begin idle(); pulse_checks("noedge", 0, 0); end

        // Late: A=0, T=1, B=1.
        tick(1, 0, 1); idle(); tick(0, 1, 1);
        for (int k = 1; k <= 5; k++) begin idle(); pulse_checks("late", k <= P, 0); end

        // No transition: A=B=1.
        tick(1, 0, 1); idle(); tick(0, 1, 1);
        for (int k = 1; k <= 4; k++) begin idle(); pulse_checks("notrans", 0, 0); end

        // Early: A=1, T=1, B=0.
        tick(1, 0, 1); idle(); tick(0, 1, 0);
        for (int k = 1; k <= 5; k++) begin idle(); pulse_checks("early", 0, k <= P); end

        // UP at n (coincident strobes), DN at n+2 using the edge captured at n.
        tick(1, 0, 1); idle(); tick(1, 1, 1);
        idle(); pulse_checks("updn1", 1, 0);
        tick(0, 1, 0); pulse_checks("updn2", 1, 0);
        for (int k = 3; k <= 7; k++) begin idle(); pulse_checks("updn", 0, k <= 6); end

        // Same direction at n and n+4 extends UP through n+8.
        tick(1, 0, 1); idle(); tick(0, 1, 1);
        idle(); pulse_checks("ext1", 1, 0);
        tick(1, 0, 0); pulse_checks("ext2", 1, 0);
        idle(); pulse_checks("ext3", 1, 0);
        tick(0, 1, 0); pulse_checks("ext4", 1, 0);
        for (int k = 5; k <= 9; k++) begin idle(); pulse_checks("ext", k <= 8, 0); end

        // Reset mid-pulse, then the first sample must not decide.
        tick(1, 0, 1); idle(); tick(0, 1, 1); idle();
        do_reset();
        tick(1, 0, 1); idle(); tick(0, 1, 0);
        for (int k = 1; k <= 4; k++) begin idle(); pulse_checks("post_rst", 0, 0); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
